vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing (800x525 total) and presents DrawX/DrawY to the sprite/background renderers.
- Takes back their registered RGB and re-aligns hsync/vsync/vde to the renderer pipeline latency.
- Blanks RGB outside the active area and drives the aligned signal set to the HDMI/VGA encoder.
- It is the driver and consumer end of the DrawX/DrawY -> RGB pixel interface that every sprite block uses.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- PIPE_DELAY, 1, cycles from DrawX/DrawY valid to the renderer's RGB valid; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- red_in  in  4  renderer red, valid PIPE_DELAY cycles after the matching DrawX/DrawY
- green_in  in  4  renderer green, same timing as red_in
- blue_in  in  4  renderer blue, same timing as red_in
- DrawX  out  10  horizontal counter hc, 0..799
- DrawY  out  10  vertical counter vc, 0..524
- line_start  out  1  one-cycle pulse when hc==0, undelayed
- frame_start  out  1  one-cycle pulse when hc==0 and vc==0, undelayed
- hsync  out  1  active-low horizontal sync, pipeline-aligned
- vsync  out  1  active-low vertical sync, pipeline-aligned
- vde  out  1  active-video enable, pipeline-aligned
- red, green, blue  out  4 each  blanked, registered RGB

Behaviour:
- Clocking and reset: one clock, vga_clk; reset is synchronous and active-high.
- Reset values: hc=vc=0; hsync=1; vsync=1; vde=0; red/green/blue=0. Every delay-line stage is loaded with inactive values (sync=1, active=0). line_start and frame_start are combinational from hc/vc, so both read 1 while reset is held.
- Counter advance: hc increments every cycle. At hc==H_TOTAL-1 (799), hc wraps to 0 and vc increments. At hc==799 with vc==V_TOTAL-1 (524), both wrap to 0.
  - H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params.
  - All counter arithmetic is unsigned 10-bit.
- DrawX/DrawY expose hc/vc directly, including blanking values. Renderers own any clamping.
- Raw (undelayed) decodes, all from hc/vc:
  - act = (hc<H_ACTIVE) && (vc<V_ACTIVE)
  - hs_n = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vs_n = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
- Alignment:
  - act, hs_n and vs_n pass through a PIPE_DELAY-stage shift register; PIPE_DELAY=0 means a direct wire.
  - At the edge ending cycle n+PIPE_DELAY, the output registers capture:
    - hsync <= hs_n delayed
    - vsync <= vs_n delayed
    - vde <= act delayed
    - rgb <= act delayed ? rgb_in : 0
- Latency: every pipeline-aligned output reflects the counter state of PIPE_DELAY+1 cycles earlier. DrawX/DrawY, line_start and frame_start have zero latency.
- Blanking: RGB output is exactly 0 whenever vde is 0, regardless of rgb_in.
- Reset mid-frame: counters return to 0 on the first edge with reset high. The delay line is flushed, so hsync/vsync cannot emit a partial low pulse after release.
- Post-release: the first cycle after reset deasserts shows DrawX=0, DrawY=0, frame_start=1.
- Pulse widths: hsync low exactly H_SYNC cycles per line. vsync low exactly V_SYNC*H_TOTAL cycles per frame; its edges coincide with hsync-aligned line boundaries.

Decomposition:
- Package vga_timing_pkg:
  - default timing constants (H_*/V_* values, H_TOTAL, V_TOTAL)
  - DRAW_W=10
  - typedef pix_rgb_t: struct of three 4-bit channels
- Sub-module sync_delay_line: parameterised DEPTH x WIDTH shift register with synchronous reset to a RESET_VAL parameter. One instance carries {act, hs_n, vs_n} with RESET_VAL 3'b011.

Test Plan:
- Reset: hold reset 3 cycles -> hsync=1, vsync=1, vde=0, rgb=0, DrawX=DrawY=0. After release, DrawX reads 0,1,2 on successive cycles.
- Line wrap: DrawX=799, DrawY=5 -> next cycle DrawX=0, DrawY=6 and line_start=1 for exactly one cycle.
- Frame wrap: (799,524) -> (0,0) with a single-cycle frame_start. Consecutive frame_start pulses are exactly 420000 cycles apart.
- Sync alignment (PIPE_DELAY=1):
  - hsync falls 2 cycles after DrawX first reads 656 and stays low 96 cycles.
  - vsync is low for 1600 cycles, starting 2 cycles after (DrawX,DrawY)=(0,490).
  - Repeat with PIPE_DELAY=0 and PIPE_DELAY=3: offsets become 1 and 4 cycles.
- Blanking: drive rgb_in = F/F/F constantly.
  - Active lines: vde high 640 consecutive cycles and rgb=F/F/F only while vde=1; rgb=0 for the other 160 cycles.
  - Lines 480..524: vde=0 and rgb=0 throughout.
- Mid-frame reset: assert reset for 1 cycle at (300,200) -> next cycle DrawX=DrawY=0. hsync/vsync stay 1 and vde stays 0 until the counters re-enter those regions naturally.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and types for the VGA raster timing generator.
//   - DEF_* : default 640x480@60 timing (800 x 525 total raster)
//   - DRAW_W: width of the DrawX/DrawY raster counters
//   - pix_rgb_t: one 12-bit pixel as three 4-bit channels
//   - in_span(): half-open range test used by the sync decoders
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DRAW_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_rgb_t;

  // True when lo <= v < hi.
  function automatic logic in_span(logic [DRAW_W-1:0] v,
                                   logic [DRAW_W-1:0] lo,
                                   logic [DRAW_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   The DrawX/DrawY -> RGB pixel interface shared by the timing generator and
//   every renderer (sprite/background) block.
//   - DrawX, DrawY         : raster position, 0..799 / 0..524, blanking included
//   - line_start           : 1 while DrawX == 0
//   - frame_start          : 1 while DrawX == 0 and DrawY == 0
//   - red_in/green_in/blue_in : renderer colour for a position
//
// Transfer contract: there is no valid/ready pair. The timing generator
// presents a new position on every pixel clock and never stalls; a renderer
// must return the colour for the position shown in cycle n during cycle
// n+PIPE_DELAY, every cycle, with no back-pressure.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [DRAW_W-1:0] DrawX;
  logic [DRAW_W-1:0] DrawY;
  logic              line_start;
  logic              frame_start;
  logic [3:0]        red_in;
  logic [3:0]        green_in;
  logic [3:0]        blue_in;

  // Timing generator side.
  modport master (
    output DrawX, DrawY, line_start, frame_start,
    input  red_in, green_in, blue_in
  );

  // Renderer side.
  modport slave (
    input  DrawX, DrawY, line_start, frame_start,
    output red_in, green_in, blue_in
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
//   DEPTH x WIDTH shift register, synchronous active-high reset that loads
//   every stage with RESET_VAL. DEPTH = 0 degenerates to a plain wire.
//   Ports:
//     i_clk  : clock
//     i_rst  : synchronous reset, active high
//     i_din  : value entering stage 0
//     o_dout : value leaving the last stage (DEPTH cycles later)
// ---------------------------------------------------------------------------
module sync_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_dout   = i_din;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else begin
          r_stage[0] <= i_din;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator (default 640x480@60, 800x525 total).
//   Drives DrawX/DrawY to the renderers, takes their colour back PIPE_DELAY
//   cycles later and re-aligns hsync/vsync/vde to it, blanking RGB outside
//   the active area.
//   Ports:
//     vga_clk          : pixel clock
//     reset            : synchronous reset, active high
//     pix (master)     : DrawX/DrawY/line_start/frame_start out, RGB in
//     hsync, vsync     : active-low syncs, aligned with the RGB outputs
//     vde              : active-video enable, aligned with the RGB outputs
//     red/green/blue   : registered RGB, forced to 0 whenever vde is 0
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master pix,
  output logic             hsync,
  output logic             vsync,
  output logic             vde,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DRAW_W-1:0] H_LAST  = DRAW_W'(H_TOTAL - 1);
  localparam logic [DRAW_W-1:0] V_LAST  = DRAW_W'(V_TOTAL - 1);
  localparam logic [DRAW_W-1:0] H_VIS   = DRAW_W'(H_ACTIVE);
  localparam logic [DRAW_W-1:0] V_VIS   = DRAW_W'(V_ACTIVE);
  localparam logic [DRAW_W-1:0] HS_BEG  = DRAW_W'(H_ACTIVE + H_FP);
  localparam logic [DRAW_W-1:0] HS_END  = DRAW_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [DRAW_W-1:0] VS_BEG  = DRAW_W'(V_ACTIVE + V_FP);
  localparam logic [DRAW_W-1:0] VS_END  = DRAW_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DRAW_W-1:0] r_hc;
  logic [DRAW_W-1:0] r_vc;

  logic       w_act;
  logic       w_hs_n;
  logic       w_vs_n;
  logic [2:0] w_align_d;   // {act, hs_n, vs_n} after PIPE_DELAY cycles

  pix_rgb_t   w_rgb_in;
  pix_rgb_t   r_rgb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_vde;

  // Raster counters: hc every cycle, vc once per line at the hc wrap.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  assign pix.DrawX       = r_hc;
  assign pix.DrawY       = r_vc;
  assign pix.line_start  = (r_hc == '0);
  assign pix.frame_start = (r_hc == '0) && (r_vc == '0);

  // Undelayed decodes of the current raster position.
  assign w_act  = (r_hc < H_VIS) && (r_vc < V_VIS);
  assign w_hs_n = ~in_span(r_hc, HS_BEG, HS_END);
  assign w_vs_n = ~in_span(r_vc, VS_BEG, VS_END);

  // Delays the decodes by the renderer latency; reset flushes it to the
  // inactive pattern so no partial sync pulse can leak out after reset.
  sync_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL (3'b011)
  ) u_align (
    .i_clk  (vga_clk),
    .i_rst  (reset),
    .i_din  ({w_act, w_hs_n, w_vs_n}),
    .o_dout (w_align_d)
  );

  assign w_rgb_in = '{r: pix.red_in, g: pix.green_in, b: pix.blue_in};

  // Output register: colour and its matching delayed decodes land together.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_vde   <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_vde   <= w_align_d[2];
      r_hsync <= w_align_d[1];
      r_vsync <= w_align_d[0];
      r_rgb   <= w_align_d[2] ? w_rgb_in : '0;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign vde   = r_vde;
  assign red   = r_rgb.r;
  assign green = r_rgb.g;
  assign blue  = r_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances (PIPE_DELAY 0, 1, 3) share clock, reset and renderer
//   colour. The vertical timing is shortened (27 lines) so whole frames fit
//   in a short run; horizontal timing is the default 800-pixel line.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int TV_ACTIVE = 20;
  localparam int TV_FP     = 2;
  localparam int TV_SYNC   = 2;
  localparam int TV_BP     = 3;
  localparam int TH_TOTAL  = DEF_H_TOTAL;
  localparam int TV_TOTAL  = TV_ACTIVE + TV_FP + TV_SYNC + TV_BP;
  localparam int FRAME     = TH_TOTAL * TV_TOTAL;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #20 vga_clk = ~vga_clk;

  logic [3:0] rin = '0;
  logic [3:0] gin = '0;
  logic [3:0] bin = '0;
  bit         rgb_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  // ---------------- DUTs ----------------
  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if3 ();

  assign if0.red_in = rin; assign if0.green_in = gin; assign if0.blue_in = bin;
  assign if1.red_in = rin; assign if1.green_in = gin; assign if1.blue_in = bin;
  assign if3.red_in = rin; assign if3.green_in = gin; assign if3.blue_in = bin;

  logic [2:0]      hs;
  logic [2:0]      vs;
  logic [2:0]      de;
  logic [2:0][3:0] ro;
  logic [2:0][3:0] go;
  logic [2:0][3:0] bo;

  vga_timing_gen #(.V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
                   .PIPE_DELAY(0)) u_d0 (
    .vga_clk(vga_clk), .reset(reset), .pix(if0.master),
    .hsync(hs[0]), .vsync(vs[0]), .vde(de[0]), .red(ro[0]), .green(go[0]), .blue(bo[0]));

  vga_timing_gen #(.V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
                   .PIPE_DELAY(1)) u_d1 (
    .vga_clk(vga_clk), .reset(reset), .pix(if1.master),
    .hsync(hs[1]), .vsync(vs[1]), .vde(de[1]), .red(ro[1]), .green(go[1]), .blue(bo[1]));

  vga_timing_gen #(.V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
                   .PIPE_DELAY(3)) u_d3 (
    .vga_clk(vga_clk), .reset(reset), .pix(if3.master),
    .hsync(hs[2]), .vsync(vs[2]), .vde(de[2]), .red(ro[2]), .green(go[2]), .blue(bo[2]));

  function automatic int dly(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [9:0] get_x(int k);
    case (k)
      0:       return if0.DrawX;
      1:       return if1.DrawX;
      default: return if3.DrawX;
    endcase
  endfunction

  function automatic logic [9:0] get_y(int k);
    case (k)
      0:       return if0.DrawY;
      1:       return if1.DrawY;
      default: return if3.DrawY;
    endcase
  endfunction

  function automatic logic get_ls(int k);
    case (k)
      0:       return if0.line_start;
      1:       return if1.line_start;
      default: return if3.line_start;
    endcase
  endfunction

  function automatic logic get_fs(int k);
    case (k)
      0:       return if0.frame_start;
      1:       return if1.frame_start;
      default: return if3.frame_start;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position p = cycles since the last reset release, modulo one frame.
  // Returns {act, hs_n, vs_n} for that raster position.
  function automatic logic [2:0] spec_decode(int pos);
    int hc;
    int vc;
    logic act;
    logic hs_n;
    logic vs_n;
    hc   = pos % TH_TOTAL;
    vc   = pos / TH_TOTAL;
    act  = (hc < DEF_H_ACTIVE) && (vc < TV_ACTIVE);
    hs_n = !((hc >= DEF_H_ACTIVE + DEF_H_FP) && (hc < DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC));
    vs_n = !((vc >= TV_ACTIVE + TV_FP) && (vc < TV_ACTIVE + TV_FP + TV_SYNC));
    return {act, hs_n, vs_n};
  endfunction

  int          cur_pos  = -1;
  bit          prev_rst = 1'b0;
  bit          h_rst [5];
  int          h_pos [5];
  logic [11:0] h_rgb [5];

  initial begin
    for (int i = 0; i < 5; i++) begin
      h_rst[i] = 1'b1;
      h_pos[i] = -1;
      h_rgb[i] = '0;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge vga_clk) begin
    bit          flush;
    logic [2:0]  dec;
    logic [11:0] e_rgb;
    int          d;

    if (prev_rst)          cur_pos = 0;
    else if (cur_pos >= 0) cur_pos = (cur_pos + 1) % FRAME;
    prev_rst = reset;

    for (int i = 4; i > 0; i--) begin
      h_rst[i] = h_rst[i-1];
      h_pos[i] = h_pos[i-1];
      h_rgb[i] = h_rgb[i-1];
    end
    h_rst[0] = reset;
    h_pos[0] = cur_pos;
    h_rgb[0] = {rin, gin, bin};

    if (cur_pos >= 0) begin
      for (int k = 0; k < 3; k++) begin
        d = dly(k);
        chk($sformatf("d%0d DrawX", d), get_x(k), cur_pos % TH_TOTAL);
        chk($sformatf("d%0d DrawY", d), get_y(k), cur_pos / TH_TOTAL);
        chk($sformatf("d%0d line_start", d), get_ls(k), (cur_pos % TH_TOTAL) == 0);
        chk($sformatf("d%0d frame_start", d), get_fs(k), cur_pos == 0);

        // Aligned outputs show the position of d+1 cycles ago, unless a
        // reset occurred anywhere in that window.
        flush = 1'b0;
        for (int a = 1; a <= d + 1; a++) if (h_rst[a]) flush = 1'b1;
        if (flush) dec = 3'b011;
        else       dec = spec_decode(h_pos[d+1]);
        e_rgb = dec[2] ? h_rgb[1] : 12'h000;

        chk($sformatf("d%0d vde", d),   de[k], dec[2]);
        chk($sformatf("d%0d hsync", d), hs[k], dec[1]);
        chk($sformatf("d%0d vsync", d), vs[k], dec[0]);
        chk($sformatf("d%0d rgb", d),   {ro[k], go[k], bo[k]}, e_rgb);
      end
    end
  end

  // ---------------- colour driver ----------------
  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      if (rgb_rand) {rin, gin, bin} = 12'($urandom_range(0, 4095));
      else          {rin, gin, bin} = 12'hFFF;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_xy(int x, int y, int budget, string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge vga_clk);
      n++;
      hit = (if1.DrawX == 10'(x)) && (if1.DrawY == 10'(y));
    end
    chk({name, " reached"}, hit, 1'b1);
  endtask

  // One-cycle reset during the cycle showing (x, y).
  task automatic pulse_reset_at(int x, int y, string name);
    wait_xy(x - 1, y, FRAME + 100, name);
    @(posedge vga_clk); #1; reset = 1'b1;
    @(posedge vga_clk); #1; reset = 1'b0;
    @(negedge vga_clk);
    chk({name, " DrawX"}, if1.DrawX, 0);
    chk({name, " DrawY"}, if1.DrawY, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d hsync", name, dly(k)), hs[k], 1'b1);
      chk($sformatf("%s d%0d vsync", name, dly(k)), vs[k], 1'b1);
      chk($sformatf("%s d%0d vde", name, dly(k)), de[k], 1'b0);
    end
  endtask

  // Over a window starting at the current cycle, record the first cycle at
  // which each sync is low and how many cycles it is low in total.
  task automatic measure_low(bit use_v, int window, string name, int exp_ofs, int exp_len);
    int first [3];
    int cnt   [3];
    logic s;
    for (int k = 0; k < 3; k++) begin first[k] = -1; cnt[k] = 0; end
    for (int i = 1; i <= window; i++) begin
      @(negedge vga_clk);
      for (int k = 0; k < 3; k++) begin
        s = use_v ? vs[k] : hs[k];
        if (s == 1'b0) begin
          cnt[k]++;
          if (first[k] < 0) first[k] = i;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d offset", name, dly(k)), first[k], exp_ofs + dly(k));
      chk($sformatf("%s d%0d width", name, dly(k)), cnt[k], exp_len);
    end
  endtask

  // Count vde-high cycles and cycles with full-white RGB over one line.
  task automatic measure_line(string name, int exp_de, int exp_white);
    int n_de  [3];
    int n_wht [3];
    for (int k = 0; k < 3; k++) begin n_de[k] = 0; n_wht[k] = 0; end
    repeat (TH_TOTAL) begin
      @(negedge vga_clk);
      for (int k = 0; k < 3; k++) begin
        if (de[k] == 1'b1) n_de[k]++;
        if ({ro[k], go[k], bo[k]} == 12'hFFF) n_wht[k]++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d vde count", name, dly(k)), n_de[k], exp_de);
      chk($sformatf("%s d%0d white count", name, dly(k)), n_wht[k], exp_white);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int lows;

    // Reset held for three edges.
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("reset hsync", hs[1], 1'b1);
    chk("reset vsync", vs[1], 1'b1);
    chk("reset vde",   de[1], 1'b0);
    chk("reset rgb",   {ro[1], go[1], bo[1]}, 12'h000);
    chk("reset DrawX", if1.DrawX, 0);
    chk("reset DrawY", if1.DrawY, 0);
    chk("reset line_start", if1.line_start, 1'b1);
    @(posedge vga_clk); #1; reset = 1'b0; rgb_rand = 1'b1;
    @(negedge vga_clk);
    chk("release DrawX 0", if1.DrawX, 0);
    chk("release frame_start", if1.frame_start, 1'b1);
    @(negedge vga_clk);
    chk("release DrawX 1", if1.DrawX, 1);
    chk("release frame_start low", if1.frame_start, 1'b0);
    @(negedge vga_clk);
    chk("release DrawX 2", if1.DrawX, 2);

    // Line wrap.
    wait_xy(799, 5, FRAME, "line wrap");
    @(negedge vga_clk);
    chk("wrap DrawX", if1.DrawX, 0);
    chk("wrap DrawY", if1.DrawY, 6);
    chk("wrap line_start", if1.line_start, 1'b1);
    @(negedge vga_clk);
    chk("wrap line_start low", if1.line_start, 1'b0);

    // Hsync: falls d+1 cycles after DrawX reads 656, low for 96.
    wait_xy(656, 6, FRAME, "hsync start");
    measure_low(1'b0, 110, "hsync", 1, 96);

    // Blanking with constant white colour.
    rgb_rand = 1'b0;
    wait_xy(0, 7, FRAME, "active line");
    measure_line("active line", 640, 640);

    // Vsync: two lines low, d+1 cycles after (0, 22); no video there.
    wait_xy(0, 22, FRAME, "vsync start");
    measure_low(1'b1, 1610, "vsync", 1, 1600);
    wait_xy(0, 25, FRAME, "blank line");
    measure_line("blank line", 0, 0);

    // Frame wrap and frame period.
    rgb_rand = 1'b1;
    wait_xy(799, TV_TOTAL - 1, FRAME, "frame wrap");
    @(negedge vga_clk);
    chk("frame wrap DrawX", if1.DrawX, 0);
    chk("frame wrap DrawY", if1.DrawY, 0);
    chk("frame wrap frame_start", if1.frame_start, 1'b1);
    n = 0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (if1.frame_start != 1'b1 && n < FRAME + 100);
    chk("frame period", n, 21600);

    // Mid-frame resets: one in plain video, one inside an hsync pulse.
    pulse_reset_at(300, 10, "reset at 300,10");
    pulse_reset_at(700, 12, "reset at 700,12");
    lows = 0;
    repeat (200) begin
      @(negedge vga_clk);
      for (int k = 0; k < 3; k++) if (hs[k] == 1'b0) lows++;
    end
    chk("no hsync after reset", lows, 0);

    repeat (10) @(negedge vga_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
